// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue and the IF/ID stages around it.
// Holds default widths, the fetch entry layout and exception-bit positions.
package ifq_pkg;

    localparam int IFQ_DEPTH   = 4;
    localparam int IFQ_ADDR_W  = 32;
    localparam int IFQ_INSTR_W = 32;
    localparam int IFQ_EXC_W   = 8;

    // Bit positions inside the if_except vector
    localparam int EXC_ADEL_IF = 0;
    localparam int EXC_TLBL_IF = 1;
    localparam int EXC_SYSCALL = 2;
    localparam int EXC_BREAK   = 3;
    localparam int EXC_RI      = 4;
    localparam int EXC_OV      = 5;
    localparam int EXC_ERET    = 6;
    localparam int EXC_INT     = 7;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0]  pc;
        logic [IFQ_INSTR_W-1:0] instr;
        logic [IFQ_EXC_W-1:0]   except;
        logic                   delayslot;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one async read port.
// Contents are deliberately not reset; occupancy logic in the top qualifies them.
import ifq_pkg::*;

module ifq_storage #(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int W     = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch queue between IF and if2id: buffers fetched instructions so a fetch stall
// and an ID stall no longer freeze each other. Supports full and keep-head flushes.
import ifq_pkg::*;

module inst_fetch_queue #(
    parameter int DEPTH   = IFQ_DEPTH,
    parameter int ADDR_W  = IFQ_ADDR_W,
    parameter int INSTR_W = IFQ_INSTR_W,
    parameter int EXC_W   = IFQ_EXC_W,
    parameter int BYPASS  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic [EXC_W-1:0]         push_except,
    input  logic                     push_delayslot,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [ADDR_W-1:0]        pop_pc,
    output logic [INSTR_W-1:0]       pop_instr,
    output logic [EXC_W-1:0]         pop_except,
    output logic                     pop_delayslot,
    output logic [ADDR_W-1:0]        pop_pc4,
    input  logic                     flush_all,
    input  logic                     flush_keep_head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic [EXC_W-1:0]   except;
        logic               delayslot;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] rd_raw;
    entry_t        push_ent, rd_ent, head_ent;
    logic          q_empty, q_full, byp_path;
    logic          push_fire, pop_fire, byp_fire, pop_adv, we;

    assign push_ent = {push_pc, push_instr, push_except, push_delayslot};
    assign rd_ent   = entry_t'(rd_raw);

    assign q_empty  = (count_q == '0);
    assign q_full   = (count_q == CW'(DEPTH));
    assign byp_path = (BYPASS != 0) && q_empty;

    assign push_ready = !q_full;
    assign pop_valid  = !flush_all && (!q_empty || (byp_path && push_valid));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;
    // A bypassed push that is consumed in the same cycle never touches storage
    assign byp_fire   = byp_path && push_fire && pop_fire;
    assign pop_adv    = pop_fire && !byp_fire;

    assign head_ent      = byp_path ? push_ent : rd_ent;
    assign pop_pc        = pop_valid ? head_ent.pc        : '0;
    assign pop_instr     = pop_valid ? head_ent.instr     : '0;
    assign pop_except    = pop_valid ? head_ent.except    : '0;
    assign pop_delayslot = pop_valid ? head_ent.delayslot : 1'b0;
    assign pop_pc4       = pop_valid ? head_ent.pc + ADDR_W'(4) : '0;

    assign count = count_q;
    assign full  = q_full;
    assign empty = q_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        we       = 1'b0;
        if (flush_all) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else if (flush_keep_head) begin
            if (pop_fire) begin
                // The delay slot leaves through ID this cycle, so nothing survives
                count_d  = '0;
                rd_ptr_d = byp_fire ? rd_ptr_q : rd_ptr_q + PW'(1);
                wr_ptr_d = rd_ptr_d;
            end else if (!q_empty) begin
                count_d  = CW'(1);
                wr_ptr_d = rd_ptr_q + PW'(1);
            end else if (push_fire) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = CW'(1);
            end
        end else begin
            we = push_fire && !byp_fire;
            if (we)      wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_adv) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(we) - CW'(pop_adv);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (push_ent),
        .raddr (rd_ptr_q),
        .rdata (rd_raw)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: one plain and one bypass instance on shared stimulus,
// each checked every cycle against a list-based model, plus directed vectors.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_delayslot, pop_ready, flush_all, flush_keep_head;
    logic [31:0] push_pc, push_instr;
    logic [7:0]  push_except;

    logic        a_push_ready, a_pop_valid, a_pop_delayslot, a_full, a_empty;
    logic [31:0] a_pop_pc, a_pop_instr, a_pop_pc4;
    logic [7:0]  a_pop_except;
    logic [2:0]  a_count;
    logic        b_push_ready, b_pop_valid, b_pop_delayslot, b_full, b_empty;
    logic [31:0] b_pop_pc, b_pop_instr, b_pop_pc4;
    logic [7:0]  b_pop_except;
    logic [2:0]  b_count;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4), .BYPASS(0)) dut_a (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(a_push_ready),
        .push_pc(push_pc), .push_instr(push_instr), .push_except(push_except),
        .push_delayslot(push_delayslot), .pop_valid(a_pop_valid), .pop_ready(pop_ready),
        .pop_pc(a_pop_pc), .pop_instr(a_pop_instr), .pop_except(a_pop_except),
        .pop_delayslot(a_pop_delayslot), .pop_pc4(a_pop_pc4), .flush_all(flush_all),
        .flush_keep_head(flush_keep_head), .count(a_count), .full(a_full), .empty(a_empty)
    );

    inst_fetch_queue #(.DEPTH(4), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(b_push_ready),
        .push_pc(push_pc), .push_instr(push_instr), .push_except(push_except),
        .push_delayslot(push_delayslot), .pop_valid(b_pop_valid), .pop_ready(pop_ready),
        .pop_pc(b_pop_pc), .pop_instr(b_pop_instr), .pop_except(b_pop_except),
        .pop_delayslot(b_pop_delayslot), .pop_pc4(b_pop_pc4), .flush_all(flush_all),
        .flush_keep_head(flush_keep_head), .count(b_count), .full(b_full), .empty(b_empty)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  exc;
        logic        ds;
    } ent_t;

    typedef struct {
        bit          pv;
        logic [31:0] pc;
        bit          pr, fa, fk;
        bit          e_pv;
        logic [31:0] e_pc;
        int          e_cnt;
        bit          e_prdy;
    } vec_t;

    // Model: per instance an ordered list, element 0 is the head
    ent_t ma [2][4];
    int   msz [2];
    bit   m_pf [2];
    bit   m_popf [2];
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic ent_t cur_push();
        ent_t e;
        e.pc = push_pc; e.instr = push_instr; e.exc = push_except; e.ds = push_delayslot;
        return e;
    endfunction

    task automatic set_in(input bit pv, input logic [31:0] pc, input bit pr, input bit fa, input bit fk);
        push_valid      = pv;
        push_pc         = pc;
        push_instr      = ~pc ^ 32'h1234_5678;
        push_except     = pc[9:2];
        push_delayslot  = pc[2];
        pop_ready       = pr;
        flush_all       = fa;
        flush_keep_head = fk;
    endtask

    task automatic check_inst(input int k, input logic pv, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [7:0] exc, input logic ds,
                              input logic [31:0] pc4, input logic [2:0] cnt, input logic prdy,
                              input logic fl, input logic em);
        string nm;
        ent_t  h;
        bit    epv;
        nm  = (k == 1) ? "B" : "A";
        epv = !flush_all && (msz[k] > 0 || (k == 1 && push_valid));
        h   = (msz[k] > 0) ? ma[k][0] : cur_push();
        if (!epv) begin
            h.pc = '0; h.instr = '0; h.exc = '0; h.ds = 1'b0;
        end
        chk({nm, ".pop_valid"},  32'(pv),    32'(epv));
        chk({nm, ".pop_pc"},     pc,         h.pc);
        chk({nm, ".pop_instr"},  instr,      h.instr);
        chk({nm, ".pop_except"}, 32'(exc),   32'(h.exc));
        chk({nm, ".pop_ds"},     32'(ds),    32'(h.ds));
        chk({nm, ".pop_pc4"},    pc4,        epv ? h.pc + 32'd4 : 32'd0);
        chk({nm, ".count"},      32'(cnt),   32'(msz[k]));
        chk({nm, ".push_ready"}, 32'(prdy),  32'(msz[k] != 4));
        chk({nm, ".full"},       32'(fl),    32'(msz[k] == 4));
        chk({nm, ".empty"},      32'(em),    32'(msz[k] == 0));
        m_pf[k]   = push_valid && msz[k] < 4;
        m_popf[k] = epv && pop_ready;
    endtask

    task automatic model_update(input int k);
        if (flush_all) begin
            msz[k] = 0;
        end else if (flush_keep_head) begin
            if (m_popf[k])       msz[k] = 0;
            else if (msz[k] > 0) msz[k] = 1;
            else if (m_pf[k]) begin
                ma[k][0] = cur_push();
                msz[k]   = 1;
            end
        end else if (!(k == 1 && msz[k] == 0 && m_pf[k] && m_popf[k])) begin
            if (m_popf[k]) begin
                for (int j = 0; j < 3; j++) ma[k][j] = ma[k][j+1];
                msz[k]--;
            end
            if (m_pf[k]) begin
                ma[k][msz[k]] = cur_push();
                msz[k]++;
            end
        end
    endtask

    // Called at the negative edge; finishes the cycle one step after the rising edge
    task automatic sample_and_advance();
        check_inst(0, a_pop_valid, a_pop_pc, a_pop_instr, a_pop_except, a_pop_delayslot,
                   a_pop_pc4, a_count, a_push_ready, a_full, a_empty);
        check_inst(1, b_pop_valid, b_pop_pc, b_pop_instr, b_pop_except, b_pop_delayslot,
                   b_pop_pc4, b_count, b_push_ready, b_full, b_empty);
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample_and_advance();
    endtask

    function automatic vec_t mk(input bit pv, input logic [31:0] pc, input bit pr, input bit fa,
                                input bit fk, input bit epv, input logic [31:0] epc,
                                input int ecnt, input bit eprdy);
        vec_t v;
        v.pv = pv; v.pc = pc; v.pr = pr; v.fa = fa; v.fk = fk;
        v.e_pv = epv; v.e_pc = epc; v.e_cnt = ecnt; v.e_prdy = eprdy;
        return v;
    endfunction

    task automatic do_reset();
        set_in(0, 32'h0, 0, 0, 0);
        rst = 1'b0;
        msz[0] = 0;
        msz[1] = 0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b0;
        msz[0] = 0;
        msz[1] = 0;
        set_in(0, 32'h0, 0, 0, 0);
        #2;
        chk("reset.count",      32'(a_count),      32'd0);
        chk("reset.push_ready", 32'(a_push_ready), 32'd1);
        chk("reset.pop_valid",  32'(b_pop_valid),  32'd0);
        do_reset();

        // Fill and drain
        tbl.push_back(mk(1, 32'hBFC00000, 0, 0, 0, 0, 32'h0,        0, 1));
        tbl.push_back(mk(1, 32'hBFC00004, 0, 0, 0, 1, 32'hBFC00000, 1, 1));
        tbl.push_back(mk(1, 32'hBFC00008, 0, 0, 0, 1, 32'hBFC00000, 2, 1));
        tbl.push_back(mk(1, 32'hBFC0000C, 0, 0, 0, 1, 32'hBFC00000, 3, 1));
        tbl.push_back(mk(1, 32'hBFC00010, 0, 0, 0, 1, 32'hBFC00000, 4, 0));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 32'hBFC00000, 4, 0));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 32'hBFC00004, 3, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 32'hBFC00008, 2, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 1, 32'hBFC0000C, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 1));
        // Wrap-around with count held at 2
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 32'h0,   0, 1));
        tbl.push_back(mk(1, 32'h104, 0, 0, 0, 1, 32'h100, 1, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 32'h108 + 32'(4*i), 1, 0, 0, 1, 32'h100 + 32'(4*i), 2, 1));
        // flush_all at count 3 with a push present
        tbl.push_back(mk(1, 32'h130,      0, 0, 0, 1, 32'h128, 2, 1));
        tbl.push_back(mk(1, 32'hDEAD0000, 1, 1, 0, 0, 32'h0,   3, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 1));
        // flush_keep_head without and with a pop
        tbl.push_back(mk(1, 32'h80000010, 0, 0, 0, 0, 32'h0,        0, 1));
        tbl.push_back(mk(1, 32'h80000014, 0, 0, 0, 1, 32'h80000010, 1, 1));
        tbl.push_back(mk(1, 32'h80000018, 0, 0, 0, 1, 32'h80000010, 2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 1, 32'h80000010, 3, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 0, 1, 32'h80000010, 1, 1));
        tbl.push_back(mk(1, 32'h80000020, 0, 0, 0, 1, 32'h80000010, 1, 1));
        tbl.push_back(mk(1, 32'h80000024, 0, 0, 0, 1, 32'h80000010, 2, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 1, 32'h80000010, 3, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1));

        foreach (tbl[i]) begin
            set_in(tbl[i].pv, tbl[i].pc, tbl[i].pr, tbl[i].fa, tbl[i].fk);
            @(negedge clk);
            chk($sformatf("vec%0d.pop_valid", i),  32'(a_pop_valid),  32'(tbl[i].e_pv));
            chk($sformatf("vec%0d.pop_pc", i),     a_pop_pc,          tbl[i].e_pc);
            chk($sformatf("vec%0d.pop_pc4", i),    a_pop_pc4,         tbl[i].e_pv ? tbl[i].e_pc + 32'd4 : 32'd0);
            chk($sformatf("vec%0d.count", i),      32'(a_count),      32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.push_ready", i), 32'(a_push_ready), 32'(tbl[i].e_prdy));
            sample_and_advance();
        end

        // Bypass: empty queue forwards a push straight to pop
        do_reset();
        set_in(1, 32'h80000100, 1, 0, 0);
        @(negedge clk);
        chk("byp.pop_valid", 32'(b_pop_valid), 32'd1);
        chk("byp.pop_pc",    b_pop_pc,         32'h80000100);
        chk("byp.plain_pv",  32'(a_pop_valid), 32'd0);
        sample_and_advance();
        set_in(0, 32'h0, 1, 0, 0);
        @(negedge clk);
        chk("byp.count_after", 32'(b_count), 32'd0);
        chk("byp.empty_after", 32'(b_empty), 32'd1);
        sample_and_advance();

        // Asynchronous reset mid-cycle with two entries queued
        do_reset();
        set_in(1, 32'h80000200, 0, 0, 0);
        cycle();
        set_in(1, 32'h80000204, 0, 0, 0);
        cycle();
        set_in(0, 32'h0, 0, 0, 0);
        chk("arst.count_before", 32'(a_count), 32'd2);
        #2;
        rst = 1'b0;
        msz[0] = 0;
        msz[1] = 0;
        #1;
        chk("arst.a_pop_valid", 32'(a_pop_valid), 32'd0);
        chk("arst.a_count",     32'(a_count),     32'd0);
        chk("arst.b_pop_valid", 32'(b_pop_valid), 32'd0);
        chk("arst.b_count",     32'(b_count),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            if ((i % 500) == 7) pc = 32'hFFFF_FFFC;
            set_in($urandom_range(0, 99) < 70, pc, $urandom_range(0, 99) < 55,
                   $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
